pen_locator: RTL and testbench

//  Finds which pixel of the 8x8 matrix the light pen is over. Sweeps a single-pixel probe across the

---
 rtl/pen_locator_pkg.sv | 37 +++
 rtl/pen_locator_if.sv | 35 +++
 rtl/pen_locator_sampler.sv | 62 ++++++
 rtl/pen_locator.sv | 191 +++++++++++++++++++
 tb/tb_pen_locator.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pen_locator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pen_locator_pkg
//  Description : Shared matrix geometry, FSM encoding and pixel/coordinate
//                helpers for the light-pen locator.
//  Revision    : 1.0  initial release
// ============================================================================
package pen_locator_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int COORD_W    = 3;
    localparam int PIX_W      = 6;
    localparam int CONF_W     = 4;

    // Last pixel of a row-major sweep of the whole matrix
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(MATRIX_DIM * MATRIX_DIM - 1);

    typedef enum logic [0:0] {
        PL_IDLE  = 1'b0,
        PL_PROBE = 1'b1
    } pl_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } pix_coord_t;

    // Row-major pixel index to (row,col)
    function automatic pix_coord_t pix_to_coord(input logic [PIX_W-1:0] pix);
        pix_coord_t c;
        c.row = pix[PIX_W-1:COORD_W];
        c.col = pix[COORD_W-1:0];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pen_locator_if.sv
`default_nettype none
// ============================================================================
//  Module      : pen_locator_if
//  Description : Probe drive and confirmed-hit handshake between the pen
//                locator and the matrix/frame-buffer driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface pen_locator_if;
    import pen_locator_pkg::*;

    logic               probe_active;
    logic [COORD_W-1:0] probe_row;
    logic [COORD_W-1:0] probe_col;
    logic               hit_valid;
    logic [COORD_W-1:0] hit_row;
    logic [COORD_W-1:0] hit_col;
    logic               hit_ready;
    logic               overflow;

    // Locator side
    modport master (
        output probe_active, probe_row, probe_col,
        output hit_valid, hit_row, hit_col, overflow,
        input  hit_ready
    );

    // Matrix driver side
    modport slave (
        input  probe_active, probe_row, probe_col,
        input  hit_valid, hit_row, hit_col, overflow,
        output hit_ready
    );

endinterface
`default_nettype wire

// File: rtl/pen_locator_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : pen_locator_sampler
//  Description : Synchronises the raw pen photodiode, counts pen-high cycles
//                inside the sample window of the probed pixel and flags a hit
//                on the last dwell cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module pen_locator_sampler #(
    parameter int MIN_HIGH = 8
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  pen_raw,
    input  wire  active,
    input  wire  in_window,
    input  wire  pix_end,
    output logic hit
);

    localparam int               c_high_w   = $clog2(MIN_HIGH + 1);
    localparam logic [c_high_w-1:0] c_high_max = c_high_w'(MIN_HIGH);

    logic                r_sync1;
    logic                r_pen_s;
    logic [c_high_w-1:0] r_high_cnt;
    logic [c_high_w-1:0] w_high_next;

    // Two-flop synchroniser for the asynchronous pen input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_pen_s <= 1'b0;
        end else begin
            r_sync1 <= pen_raw;
            r_pen_s <= r_sync1;
        end
    end

    // Saturating count including the current cycle, so the last window cycle counts
    always_comb begin
        w_high_next = r_high_cnt;
        if (active && in_window && r_pen_s && (r_high_cnt != c_high_max)) begin
            w_high_next = r_high_cnt + 1'b1;
        end
    end

    assign hit = active && pix_end && (w_high_next == c_high_max);

    // High counter restarts for every pixel and whenever probing stops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_cnt <= '0;
        end else if (!active || pix_end) begin
            r_high_cnt <= '0;
        end else begin
            r_high_cnt <= w_high_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pen_locator.sv
`default_nettype none
// ============================================================================
//  Module      : pen_locator
//  Description : Sweeps a single-pixel probe over the 8x8 matrix, confirms
//                the first pen hit over several sweeps and hands one (row,col)
//                write request per pen placement to the matrix driver.
//  Revision    : 1.0  initial release
// ============================================================================
module pen_locator
    import pen_locator_pkg::*;
#(
    parameter int DWELL_CYC  = 1000,
    parameter int SAMPLE_CYC = 400,
    parameter int MIN_HIGH   = 8,
    parameter int CONFIRM    = 3
) (
    input  wire           clk,
    input  wire           rst_n,
    input  wire           en,
    input  wire           pen_i,
    pen_locator_if.master bus
);

    localparam int                   c_dwell_w    = $clog2(DWELL_CYC);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL_CYC - 1);
    localparam logic [c_dwell_w-1:0] c_win_start  = c_dwell_w'(DWELL_CYC - SAMPLE_CYC);
    localparam logic [CONF_W-1:0]    c_conf_max   = CONF_W'(CONFIRM);

    pl_state_t            r_state;
    pl_state_t            w_state_next;
    logic [c_dwell_w-1:0] r_dwell;
    logic [PIX_W-1:0]     r_pix;
    logic                 r_sweep_hit;
    logic [PIX_W-1:0]     r_first_pix;
    logic                 r_cand_valid;
    logic [PIX_W-1:0]     r_cand_pix;
    logic [CONF_W-1:0]    r_conf_cnt;
    logic                 r_armed;
    logic                 r_hit_valid;
    logic [PIX_W-1:0]     r_hit_pix;
    logic                 r_overflow;

    logic                 w_active;
    logic                 w_pix_end;
    logic                 w_sweep_end;
    logic                 w_in_window;
    logic                 w_pix_hit;
    logic                 w_any_hit;
    logic [PIX_W-1:0]     w_first_pix;
    logic                 w_same_cand;
    logic [CONF_W-1:0]    w_conf_next;
    logic                 w_armed_eff;
    logic                 w_emit;
    pix_coord_t           w_probe_xy;
    pix_coord_t           w_hit_xy;

    // Probing only counts while the FSM is probing and enable is still high
    assign w_active    = (r_state == PL_PROBE) && en;
    assign w_pix_end   = w_active && (r_dwell == c_dwell_last);
    assign w_sweep_end = w_pix_end && (r_pix == LAST_PIX);
    assign w_in_window = (r_dwell >= c_win_start);

    pen_locator_sampler #(
        .MIN_HIGH (MIN_HIGH)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .pen_raw   (pen_i),
        .active    (w_active),
        .in_window (w_in_window),
        .pix_end   (w_pix_end),
        .hit       (w_pix_hit)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: probe while enabled, abort immediately on disable
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PL_IDLE:  if (en)  w_state_next = PL_PROBE;
            PL_PROBE: if (!en) w_state_next = PL_IDLE;
            default:  w_state_next = PL_IDLE;
        endcase
    end

    // Dwell and pixel counters; pixel index wraps 63 -> 0 by width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_pix   <= '0;
        end else if (!w_active) begin
            r_dwell <= '0;
            r_pix   <= '0;
        end else if (w_pix_end) begin
            r_dwell <= '0;
            r_pix   <= r_pix + 1'b1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Sweep-end confirmation decision, including a hit on pixel 63 itself
    always_comb begin
        w_any_hit   = r_sweep_hit || w_pix_hit;
        w_first_pix = r_sweep_hit ? r_first_pix : r_pix;
        w_same_cand = w_any_hit && r_cand_valid && (r_cand_pix == w_first_pix);
        w_conf_next = CONF_W'(1);
        if (!w_any_hit) begin
            w_conf_next = '0;
        end else if (w_same_cand) begin
            w_conf_next = (r_conf_cnt == c_conf_max) ? r_conf_cnt : r_conf_cnt + 1'b1;
        end
        // A no-hit sweep or a new candidate re-arms emission
        w_armed_eff = r_armed || !w_same_cand;
        w_emit      = w_sweep_end && w_any_hit && (w_conf_next == c_conf_max) && w_armed_eff;
    end

    // First-hit capture within a sweep and candidate/confirm tracking across sweeps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_hit  <= 1'b0;
            r_first_pix  <= '0;
            r_cand_valid <= 1'b0;
            r_cand_pix   <= '0;
            r_conf_cnt   <= '0;
            r_armed      <= 1'b1;
        end else if (!w_active) begin
            r_sweep_hit  <= 1'b0;
            r_first_pix  <= '0;
            r_cand_valid <= 1'b0;
            r_cand_pix   <= '0;
            r_conf_cnt   <= '0;
            r_armed      <= 1'b1;
        end else if (w_sweep_end) begin
            r_sweep_hit  <= 1'b0;
            r_first_pix  <= '0;
            r_cand_valid <= w_any_hit;
            r_cand_pix   <= w_any_hit ? w_first_pix : '0;
            r_conf_cnt   <= w_conf_next;
            r_armed      <= w_armed_eff && !w_emit;
        end else if (w_pix_hit && !r_sweep_hit) begin
            r_sweep_hit  <= 1'b1;
            r_first_pix  <= r_pix;
        end
    end

    // Hit output register: load when free or being accepted, else drop and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_valid <= 1'b0;
            r_hit_pix   <= '0;
        end else if (w_emit && (!r_hit_valid || bus.hit_ready)) begin
            r_hit_valid <= 1'b1;
            r_hit_pix   <= w_first_pix;
        end else if (r_hit_valid && bus.hit_ready) begin
            r_hit_valid <= 1'b0;
        end
    end

    // Sticky overflow, cleared whenever the locator is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (!en) begin
            r_overflow <= 1'b0;
        end else if (w_emit && r_hit_valid && !bus.hit_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_probe_xy       = pix_to_coord(r_pix);
    assign w_hit_xy         = pix_to_coord(r_hit_pix);

    assign bus.probe_active = (r_state == PL_PROBE);
    assign bus.probe_row    = w_probe_xy.row;
    assign bus.probe_col    = w_probe_xy.col;
    assign bus.hit_valid    = r_hit_valid;
    assign bus.hit_row      = w_hit_xy.row;
    assign bus.hit_col      = w_hit_xy.col;
    assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pen_locator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pen_locator
//  Description : Directed self-checking bench for pen_locator with a short
//                dwell; pen stimulus follows the bench's own sweep position.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pen_locator;

    localparam int c_dwell   = 20;
    localparam int c_sample  = 8;
    localparam int c_minhigh = 3;
    localparam int c_confirm = 3;

    // Pen pulse ranges in dwell cycles; synchroniser shifts them by +2
    localparam int c_full_lo = 11, c_full_hi = 15;   // 5 synced cycles in window -> hit
    localparam int c_weak_lo = 11, c_weak_hi = 12;   // 2 synced cycles in window -> no hit
    localparam int c_out_lo  = 2,  c_out_hi  = 9;    // synced cycles 4..11, all before window

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic pen_i = 1'b0;

    pen_locator_if bus ();

    pen_locator #(
        .DWELL_CYC  (c_dwell),
        .SAMPLE_CYC (c_sample),
        .MIN_HIGH   (c_minhigh),
        .CONFIRM    (c_confirm)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .pen_i (pen_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bench view of the sweep position and pen targets
    int m_state = 0, m_d = 0, m_p = 0;
    int tgt_a = -1, tgt_b = -1, pen_lo = 0, pen_hi = -1;

    // Track sweep position from en/rst_n and drive the pen accordingly
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !en) begin
                m_state = 0; m_d = 0; m_p = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_d = 0; m_p = 0;
            end else if (m_d == c_dwell - 1) begin
                m_d = 0; m_p = (m_p + 1) % 64;
            end else begin
                m_d = m_d + 1;
            end
            pen_i = (m_state == 1) && ((m_p == tgt_a) || (m_p == tgt_b)) &&
                    (m_d >= pen_lo) && (m_d <= pen_hi);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".probe_active"}, 32'(bus.probe_active), 0);
        check_val({tag, ".probe_row"},    32'(bus.probe_row),    0);
        check_val({tag, ".probe_col"},    32'(bus.probe_col),    0);
        check_val({tag, ".hit_valid"},    32'(bus.hit_valid),    0);
        check_val({tag, ".hit_row"},      32'(bus.hit_row),      0);
        check_val({tag, ".hit_col"},      32'(bus.hit_col),      0);
        check_val({tag, ".overflow"},     32'(bus.overflow),     0);
    endtask

    // Advance to the negedge where the bench position is (p,d); bounded
    task automatic wait_pos(input int p, input int d);
        int  k;
        bit  found;
        k     = 0;
        found = 0;
        while (!found && k < 4000) begin
            @(negedge clk);
            k++;
            found = (m_state == 1) && (m_p == p) && (m_d == d);
        end
        if (!found) check_val("wait_pos_timeout", 0, 1);
    endtask

    // One sweep with the given pen pattern; checks hit_valid on the last
    // cycle of pixel 63 and on the first cycle of the following sweep
    task automatic sweep_chk(input string tag, input int a, input int b, input int lo,
                             input int hi, input int exp_pre, input int exp_post);
        tgt_a = a; tgt_b = b; pen_lo = lo; pen_hi = hi;
        wait_pos(63, c_dwell - 1);
        check_val({tag, ".hv_pre"}, 32'(bus.hit_valid), exp_pre);
        @(negedge clk);
        check_val({tag, ".hv_post"}, 32'(bus.hit_valid), exp_post);
    endtask

    initial begin
        bus.hit_ready = 1'b0;

        // 1: reset state, probe advance, reset mid-sweep
        repeat (3) @(negedge clk);
        check_zero("rst0");
        rst_n = 1'b1;
        en    = 1'b1;
        wait_pos(0, 0);
        check_val("t1.active", 32'(bus.probe_active), 1);
        check_val("t1.p0_col", 32'(bus.probe_col), 0);
        wait_pos(0, c_dwell - 1);
        check_val("t1.p0_last_col", 32'(bus.probe_col), 0);
        wait_pos(1, 0);
        check_val("t1.p1_col", 32'(bus.probe_col), 1);
        wait_pos(10, 7);
        check_val("t1.p10_row", 32'(bus.probe_row), 1);
        check_val("t1.p10_col", 32'(bus.probe_col), 2);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_pos(0, 0);
        check_val("t1.restart_active", 32'(bus.probe_active), 1);
        check_val("t1.restart_row", 32'(bus.probe_row), 0);

        // 2: pen on (2,5) = pixel 21, emits once after third sweep
        sweep_chk("t2.s1", 21, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t2.s2", 21, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t2.s3", 21, -1, c_full_lo, c_full_hi, 0, 1);
        check_val("t2.row", 32'(bus.hit_row), 2);
        check_val("t2.col", 32'(bus.hit_col), 5);
        bus.hit_ready = 1'b1;
        @(negedge clk);
        check_val("t2.accepted", 32'(bus.hit_valid), 0);
        sweep_chk("t2.s4", 21, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t2.s5", 21, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t2.s6", 21, -1, c_full_lo, c_full_hi, 0, 0);
        check_val("t2.overflow", 32'(bus.overflow), 0);

        // 3: weak and out-of-window pulses on (5,7) = pixel 47 are not hits
        sweep_chk("t3.weak", 47, -1, c_weak_lo, c_weak_hi, 0, 0);
        sweep_chk("t3.f1",   47, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t3.f2",   47, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t3.out",  47, -1, c_out_lo,  c_out_hi,  0, 0);
        sweep_chk("t3.f3",   47, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t3.f4",   47, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t3.f5",   47, -1, c_full_lo, c_full_hi, 0, 1);
        check_val("t3.row", 32'(bus.hit_row), 5);
        check_val("t3.col", 32'(bus.hit_col), 7);

        // 4: (1,1)=9 and (6,3)=51 together -> (1,1); alternating never emits
        sweep_chk("t4.b1", 9, 51, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t4.b2", 9, 51, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t4.b3", 9, 51, c_full_lo, c_full_hi, 0, 1);
        check_val("t4.row", 32'(bus.hit_row), 1);
        check_val("t4.col", 32'(bus.hit_col), 1);
        sweep_chk("t4.alt1", 51, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t4.alt2",  9, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t4.alt3", 51, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t4.alt4",  9, -1, c_full_lo, c_full_hi, 0, 0);

        // 5: stalled downstream; second hit (7,6)=62 dropped, (3,2)=26 retained
        bus.hit_ready = 1'b0;
        sweep_chk("t5.a1", 26, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t5.a2", 26, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t5.a3", 26, -1, c_full_lo, c_full_hi, 0, 1);
        check_val("t5.ovf_first", 32'(bus.overflow), 0);
        sweep_chk("t5.lift", -1, -1, c_full_lo, c_full_hi, 1, 1);
        sweep_chk("t5.b1", 62, -1, c_full_lo, c_full_hi, 1, 1);
        sweep_chk("t5.b2", 62, -1, c_full_lo, c_full_hi, 1, 1);
        check_val("t5.ovf_before", 32'(bus.overflow), 0);
        sweep_chk("t5.b3", 62, -1, c_full_lo, c_full_hi, 1, 1);
        check_val("t5.ovf_set", 32'(bus.overflow), 1);
        check_val("t5.kept_row", 32'(bus.hit_row), 3);
        check_val("t5.kept_col", 32'(bus.hit_col), 2);
        en = 1'b0;
        @(negedge clk);
        check_val("t5.ovf_clr", 32'(bus.overflow), 0);
        check_val("t5.hv_kept", 32'(bus.hit_valid), 1);
        check_val("t5.idle", 32'(bus.probe_active), 0);
        bus.hit_ready = 1'b1;
        @(negedge clk);
        check_val("t5.drained", 32'(bus.hit_valid), 0);

        // 6: abort at pixel 40 after two confirming sweeps on (2,2)=18
        en = 1'b1;
        wait_pos(0, 0);
        sweep_chk("t6.c1", 18, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t6.c2", 18, -1, c_full_lo, c_full_hi, 0, 0);
        wait_pos(40, 5);
        check_val("t6.at40_row", 32'(bus.probe_row), 5);
        en = 1'b0;
        @(negedge clk);
        check_val("t6.abort_active", 32'(bus.probe_active), 0);
        check_val("t6.abort_row", 32'(bus.probe_row), 0);
        check_val("t6.abort_col", 32'(bus.probe_col), 0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_pos(0, 0);
        check_val("t6.re_active", 32'(bus.probe_active), 1);
        check_val("t6.re_col", 32'(bus.probe_col), 0);
        sweep_chk("t6.r1", 18, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t6.r2", 18, -1, c_full_lo, c_full_hi, 0, 0);
        sweep_chk("t6.r3", 18, -1, c_full_lo, c_full_hi, 0, 1);
        check_val("t6.row", 32'(bus.hit_row), 2);
        check_val("t6.col", 32'(bus.hit_col), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
